// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, sync-polarity encodings and window decode helper for the VGA timing generator.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam int CNT_W  = 10;
  localparam int FCNT_W = 8;
  localparam int MAX_TOTAL = 1 << CNT_W;

  // Inclusive window test on a raw position count.
  function automatic logic in_window(logic [CNT_W-1:0] pos, int lo, int hi);
    return (int'(pos) >= lo) && (int'(pos) <= hi);
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable, async active-low reset to N-1 and a registered wrap flag
// (high while count==N-1). count_nxt exposes the value the next enabled edge will load.
module vga_mod_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int N = 800,
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    count_nxt = count;
    if (en) count_nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
      wrap  <= 1'b1;
    end else if (en) begin
      count <= count_nxt;
      wrap  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: raw x/y counts, sync/active decodes and line/frame strobes.
// Define VGA_TIMING_FRAMECNT_EN to add the endframe strobe and 8-bit completed-frame counter.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             px_en,
  output logic             hsync,
  output logic             vsync,
  output logic             activevideo,
  output logic [CNT_W-1:0] x_px,
  output logic [CNT_W-1:0] y_px,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
  ,
  output logic              endframe,
  output logic [FCNT_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_ACT_W = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_W = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h, h_nxt, v, v_nxt;
  logic             h_wrap, v_wrap;
  logic             hsync_nxt, vsync_nxt, active_nxt;

  vga_mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (px_en),
    .count     (h),
    .count_nxt (h_nxt),
    .wrap      (h_wrap)
  );

  vga_mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (px_en & h_wrap),
    .count     (v),
    .count_nxt (v_nxt),
    .wrap      (v_wrap)
  );

  assign x_px = h;
  assign y_px = v;

  // Decode the position being loaded this edge so outputs line up with x_px/y_px.
  always_comb begin
    hsync_nxt  = in_window(h_nxt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt  = in_window(v_nxt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
    active_nxt = (h_nxt < H_ACT_W) && (v_nxt < V_ACT_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      activevideo <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (px_en) begin
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      activevideo <= active_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAMECNT_EN
  localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

  logic endframe_nxt;
  assign endframe_nxt = (h_nxt == H_LAST_ACT) && (v_nxt == V_LAST_ACT);

  // Counter bumps with the endframe rise, so it is settled for the following blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      endframe  <= 1'b0;
      frame_cnt <= '0;
    end else if (px_en) begin
      endframe <= endframe_nxt;
      if (endframe_nxt) frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule
